// File: rtl/ps2_kbd_rx_if.sv
// Consumer-side bundle of the PS/2 keyboard receiver: FWFT scancode FIFO read port plus status pulses.
// The instantiating scope must give FIFO_AW the same value as the receiver it connects to.
interface ps2_kbd_rx_if #(
    parameter int FIFO_AW = 3
);
    logic               rd;
    logic [7:0]         dout;
    logic               brk;
    logic               valid;
    logic [FIFO_AW:0]   count;
    logic               err;
    logic               overflow;

    modport master (
        input  rd,
        output dout, brk, valid, count, err, overflow
    );

    modport slave (
        output rd,
        input  dout, brk, valid, count, err, overflow
    );
endinterface

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: receive-only PS/2 keyboard front end (sync + glitch filter, frame FSM, FWFT FIFO).
// Build option PS2_BREAK_FLAG_EN folds a 0xF0 prefix into the brk flag of the next scancode.
module ps2_kbd_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000,
    parameter int FIFO_AW     = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ps2_clk,
    input  logic         ps2_data,
    ps2_kbd_rx_if.master kbd
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int FCW   = $clog2(FILTER_LEN + 1);
    localparam int TCW   = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_e;

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    logic             clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic [FCW-1:0]   flt_cnt_q, flt_cnt_d;
    logic             flt_clk_q, flt_clk_d;
    logic             fall_q, fall_d;
    logic             fall_bit_q;

    state_e           state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic [TCW-1:0]   to_cnt_q, to_cnt_d;
    logic             push_q, push_d;
    logic [7:0]       push_data_q, push_data_d;
    logic             push_brk_q, push_brk_d;
    logic             brk_pend_q, brk_pend_d;
    logic             err_q, err_d;

    logic [7:0]         mem_data_q [DEPTH];
    logic [DEPTH-1:0]   mem_brk_q;
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               ovf_q;
    logic               pop_s, full_s, wr_en_s;

    // Pin synchronizers, filter state and the data bit captured alongside each filtered edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            flt_cnt_q  <= '0;
            flt_clk_q  <= 1'b1;
            fall_q     <= 1'b0;
            fall_bit_q <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk;
            clk_s2_q   <= clk_s1_q;
            dat_s1_q   <= ps2_data;
            dat_s2_q   <= dat_s1_q;
            flt_cnt_q  <= flt_cnt_d;
            flt_clk_q  <= flt_clk_d;
            fall_q     <= fall_d;
            fall_bit_q <= dat_s2_q;
        end
    end

    // Filtered clock only follows the pin after FILTER_LEN consecutive differing cycles
    always_comb begin
        flt_cnt_d = '0;
        flt_clk_d = flt_clk_q;
        fall_d    = 1'b0;
        if (clk_s2_q != flt_clk_q) begin
            if (flt_cnt_q == FCW'(FILTER_LEN - 1)) begin
                flt_clk_d = clk_s2_q;
                fall_d    = flt_clk_q;
            end else begin
                flt_cnt_d = flt_cnt_q + 1'b1;
            end
        end else begin
            flt_cnt_d = '0;
        end
    end

    // Frame FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            par_q       <= 1'b0;
            to_cnt_q    <= '0;
            push_q      <= 1'b0;
            push_data_q <= 8'h00;
            push_brk_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            to_cnt_q    <= to_cnt_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            push_brk_q  <= push_brk_d;
            brk_pend_q  <= brk_pend_d;
            err_q       <= err_d;
        end
    end

    // Frame FSM next state; a stalled frame is abandoned silently after TIMEOUT_CYC idle cycles
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_d       = par_q;
        to_cnt_d    = '0;
        push_d      = 1'b0;
        push_data_d = push_data_q;
        push_brk_d  = push_brk_q;
        brk_pend_d  = brk_pend_q;
        err_d       = 1'b0;

        if ((state_q != S_IDLE) && !fall_q && (to_cnt_q == TCW'(TIMEOUT_CYC - 1))) begin
            state_d    = S_IDLE;
            brk_pend_d = 1'b0;
        end else begin
            if ((state_q != S_IDLE) && !fall_q) begin
                to_cnt_d = to_cnt_q + 1'b1;
            end else begin
                to_cnt_d = '0;
            end
            case (state_q)
                S_IDLE: begin
                    if (fall_q && !fall_bit_q) begin
                        shift_d   = 8'h00;
                        bit_cnt_d = 3'd0;
                        state_d   = S_DATA;
                    end else if (fall_q) begin
                        err_d      = 1'b1;
                        brk_pend_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_DATA: begin
                    if (fall_q) begin
                        shift_d   = {fall_bit_q, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = S_PARITY;
                        end else begin
                            state_d = S_DATA;
                        end
                    end else begin
                        state_d = S_DATA;
                    end
                end
                S_PARITY: begin
                    if (fall_q) begin
                        par_d   = fall_bit_q;
                        state_d = S_STOP;
                    end else begin
                        state_d = S_PARITY;
                    end
                end
                S_STOP: begin
                    if (fall_q) begin
                        state_d = S_IDLE;
                        if (fall_bit_q && odd_parity_ok(shift_q, par_q)) begin
`ifdef PS2_BREAK_FLAG_EN
                            if (shift_q == 8'hF0) begin
                                brk_pend_d = 1'b1;
                            end else begin
                                push_d      = 1'b1;
                                push_data_d = shift_q;
                                push_brk_d  = brk_pend_q;
                                brk_pend_d  = 1'b0;
                            end
`else
                            push_d      = 1'b1;
                            push_data_d = shift_q;
                            push_brk_d  = brk_pend_q;
                            brk_pend_d  = 1'b0;
`endif
                        end else begin
                            err_d      = 1'b1;
                            brk_pend_d = 1'b0;
                        end
                    end else begin
                        state_d = S_STOP;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // A full FIFO still accepts a push when a pop frees a slot in the same cycle
    always_comb begin
        pop_s   = kbd.rd && (count_q != '0);
        full_s  = (count_q == (FIFO_AW + 1)'(DEPTH));
        wr_en_s = push_q && (!full_s || pop_s);
        case ({wr_en_s, pop_s})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers, occupancy and the overflow pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_en_s ? wr_ptr_q + 1'b1 : wr_ptr_q;
            rd_ptr_q <= pop_s ? rd_ptr_q + 1'b1 : rd_ptr_q;
            count_q  <= count_d;
            ovf_q    <= push_q && full_s && !pop_s;
        end
    end

    // FIFO storage; contents are only observable through valid, so no reset is needed
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_data_q[wr_ptr_q] <= push_data_q;
            mem_brk_q[wr_ptr_q]  <= push_brk_q;
        end else begin
            mem_brk_q <= mem_brk_q;
        end
    end

    assign kbd.valid    = (count_q != '0);
    assign kbd.dout     = kbd.valid ? mem_data_q[rd_ptr_q] : 8'h00;
    assign kbd.brk      = kbd.valid ? mem_brk_q[rd_ptr_q] : 1'b0;
    assign kbd.count    = count_q;
    assign kbd.err      = err_q;
    assign kbd.overflow = ovf_q;
endmodule
